complex_mult_arbiter: RTL
=========================

Name: complex_mult_arbiter

Overview:
- Shares one complex multiplier instance between two requesters using the valid/ready protocol on both sides.
- Round-robin grant on the operand path; an in-order tag FIFO routes each result back to the requester that issued it.
- Sits between two client blocks and the multiplier's op_*/res_* ports.
- Drives the multiplier's sw_rst from its own sw_rst input.

Parameters:
- DATA_WIDTH, 8, width of each operand component (re_a, im_a, re_b, im_b)
- MAX_OUTSTANDING, 4, tag FIFO depth = max issued-but-unreturned operations (power of 2, >=2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- sw_rst  in  1  synchronous soft reset, active high; also forwarded to the multiplier
- req0_val / req1_val  in  1  operand valid from requester 0/1
- req0_ready / req1_ready  out  1  operand accepted (valid && ready)
- req0_data / req1_data  in  4*DATA_WIDTH  {re_a, im_a, re_b, im_b}, MSB first
- mult_op_val  out  1  operand valid to multiplier
- mult_op_ready  in  1  multiplier accepts operand
- mult_op_data  out  4*DATA_WIDTH  selected requester's data
- mult_sw_rst  out  1  equals sw_rst
- mult_res_val  in  1  result valid from multiplier
- mult_res_ready  out  1  result accepted
- mult_res_data  in  4*DATA_WIDTH  {re (2W), im (2W)}
- rsp0_val / rsp1_val  out  1  result valid to requester 0/1
- rsp0_ready / rsp1_ready  in  1  requester accepts result
- rsp0_data / rsp1_data  out  4*DATA_WIDTH  copy of mult_res_data
- grant_cnt0 / grant_cnt1  out  16  accepted-operation counters (see Optional Feature)

Behaviour:
- Reset (rstn=0, or sw_rst=1 at a clk edge):
  - FSM goes to ARB; tag FIFO is emptied; last_grant=1, so requester 0 wins first.
  - All *_val and *_ready outputs are 0; counters are 0.
  - While sw_rst=1, every output val/ready is forced to 0 combinationally.
- Issue permitted only when fifo_count < MAX_OUTSTANDING.
  - No same-cycle pop/push bypass when the FIFO is full.
- FSM state ARB:
  - If issue is permitted and any reqN_val=1, select a winner. Priority goes to the requester other than last_grant; otherwise the only valid one.
  - mult_op_val=1 and mult_op_data=winner's data, combinationally in the same cycle (zero added latency).
  - reqN_ready = (N==winner) && mult_op_ready.
  - If mult_op_ready=1: handshake completes, the winner id is pushed to the FIFO, last_grant<=winner, and the FSM stays in ARB.
  - If mult_op_ready=0: locked<=winner, go to HOLD.
- FSM state HOLD:
  - mult_op_val=1 with req[locked]_data; the selection must not change while stalled.
  - On mult_op_ready=1: push locked, last_grant<=locked, go to ARB.
  - A requester that drops val while in HOLD is a protocol violation; behaviour is undefined.
- Result path:
  - head = FIFO head id.
  - rsp[head]_val = mult_res_val && !empty; the other rsp_val = 0.
  - mult_res_ready = !empty && rsp[head]_ready.
  - On the mult_res handshake, the FIFO pops.
  - If mult_res_val=1 while the FIFO is empty, mult_res_ready stays 0 and nothing is routed.
- Simultaneous push and pop (FIFO not full): count is unchanged and both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- rsp data is passed through unregistered.

Optional Feature:
- Macro COMPLEX_MULT_ARB_STATS_EN.
- Defined:
  - grant_cnt0/grant_cnt1 increment by 1 on each accepted operand handshake of the respective requester.
  - Counters wrap from 16'hFFFF to 0 and are cleared by rstn and sw_rst.
- Not defined: the counter registers are not built and grant_cnt0/grant_cnt1 are tied to 16'h0000.

Test Plan (DATA_WIDTH=8):
- Single op: req0 data {8'd3,8'd2,8'd1,8'd4}, mult_op_ready=1 → req0_ready=1 the same cycle; rsp0 gets re=16'hFFFB (-5), im=16'h000E; rsp1_val stays 0.
- Contention: req0_val and req1_val held high for 4 ops each, ready always 1 → grant order 0,1,0,1,...; responses alternate rsp0/rsp1 in issue order.
- Stall hold: both requesters valid, mult_op_ready=0 for 3 cycles → mult_op_data is constant at the winner's data throughout; the grant completes when ready rises; the loser is served next.
- Full FIFO: MAX_OUTSTANDING=4, multiplier withholds results → exactly 4 issues, then mult_op_val=0; one result returned → the next issue is possible only from the following cycle.
- Response backpressure: head=1 with rsp1_ready=0 → mult_res_ready=0 and rsp0_val=0 even with rsp0_ready=1; when rsp1_ready rises, delivery completes in order.
- Reset mid-operation: sw_rst pulse with 3 ops outstanding → FIFO empty, all val=0, req0 wins the next arbitration; with the macro on, grant counters read 0 afterwards.

Source files
------------

// File: rtl/complex_mult_arbiter.sv
// Round-robin share of one complex multiplier by two requesters; tag FIFO routes results back (COMPLEX_MULT_ARB_STATS_EN adds grant counters).
// Zero-latency combinational op/result paths; holds the selected operand while stalled; result backpressure follows the head requester.
module complex_mult_arbiter #(
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    req0_val,
  input  logic                    req1_val,
  output logic                    req0_ready,
  output logic                    req1_ready,
  input  logic [4*DATA_WIDTH-1:0] req0_data,
  input  logic [4*DATA_WIDTH-1:0] req1_data,
  output logic                    mult_op_val,
  input  logic                    mult_op_ready,
  output logic [4*DATA_WIDTH-1:0] mult_op_data,
  output logic                    mult_sw_rst,
  input  logic                    mult_res_val,
  output logic                    mult_res_ready,
  input  logic [4*DATA_WIDTH-1:0] mult_res_data,
  output logic                    rsp0_val,
  output logic                    rsp1_val,
  input  logic                    rsp0_ready,
  input  logic                    rsp1_ready,
  output logic [4*DATA_WIDTH-1:0] rsp0_data,
  output logic [4*DATA_WIDTH-1:0] rsp1_data,
  output logic [15:0]             grant_cnt0,
  output logic [15:0]             grant_cnt1
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW:0]   MAX_CNT = (PW+1)'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;

  typedef enum logic {ARB, HOLD} state_e;

  state_e                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       locked_q, locked_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [PW:0]                count_q;
  logic                       push, pop, push_id, head, empty, issue_ok;

  assign empty    = (count_q == '0);
  assign issue_ok = (count_q < MAX_CNT);
  assign head     = tag_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    mult_op_val  = 1'b0;
    push         = 1'b0;
    push_id      = 1'b0;
    if (!sw_rst) begin
      case (state_q)
        ARB: begin
          if (issue_ok && (req0_val || req1_val)) begin
            // Contention goes to whoever did not win last; otherwise the lone requester.
            push_id     = (req0_val && req1_val) ? ~last_grant_q : req1_val;
            mult_op_val = 1'b1;
            if (mult_op_ready) begin
              push         = 1'b1;
              last_grant_d = push_id;
            end else begin
              locked_d = push_id;
              state_d  = HOLD;
            end
          end
        end
        HOLD: begin
          push_id     = locked_q;
          mult_op_val = 1'b1;
          if (mult_op_ready) begin
            push         = 1'b1;
            last_grant_d = locked_q;
            state_d      = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign mult_op_data = push_id ? req1_data : req0_data;
  assign req0_ready   = mult_op_val && !push_id && mult_op_ready;
  assign req1_ready   = mult_op_val &&  push_id && mult_op_ready;

  // Results are only routed while an issued operation is outstanding.
  assign rsp0_val       = !sw_rst && !empty && mult_res_val && !head;
  assign rsp1_val       = !sw_rst && !empty && mult_res_val &&  head;
  assign mult_res_ready = !sw_rst && !empty && (head ? rsp1_ready : rsp0_ready);
  assign pop            = mult_res_val && mult_res_ready;
  assign rsp0_data      = mult_res_data;
  assign rsp1_data      = mult_res_data;
  assign mult_sw_rst    = sw_rst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      locked_q     <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else if (sw_rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      locked_q     <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      if (push) begin
        tag_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef COMPLEX_MULT_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else if (sw_rst) begin
      cnt0_q <= 16'h0000;
      cnt1_q <= 16'h0000;
    end else begin
      if (req0_val && req0_ready) cnt0_q <= cnt0_q + 16'd1;
      if (req1_val && req1_ready) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = 16'h0000;
  assign grant_cnt1 = 16'h0000;
`endif

endmodule
